run8_pattern_gen: RTL and testbench
===================================

// Module: run8_pattern_gen
// PURPOSE
//   Consumer end of the 8-way running-light step counter. Takes the counter's
//   one-cycle step strobe and drives the 8 LEDs with a selectable pattern.
//   Two raw push-buttons (mode, pause) are synchronised and debounced inside
//   the block and turned into single-cycle press pulses.
//   Sits between the step counter/prescaler and the board LED pins.
// PARAMETERS
//   DB_CYCLES  20  consecutive stable samples before a key level is accepted (>=2)
//   DB_W       5   width of debounce counter; must hold DB_CYCLES
// PORTS
//   clk        in   1  system clock, all logic on posedge
//   rst        in   1  synchronous, active-high reset
//   step       in   1  one-cycle advance strobe (counter carry-out)
//   key_mode   in   1  raw mode button, asynchronous, 1 = pressed
//   key_pause  in   1  raw pause button, asynchronous, 1 = pressed
//   led        out  8  LED pattern, registered; bit0 = rightmost LED
//   mode       out  2  current pattern mode (0..3)
//   paused     out  1  1 = steps ignored
//   wrap       out  1  one-cycle pulse when the pattern returns to its start value
// BEHAVIOUR
//   Reset (rst high at a posedge): led=8'h01, mode=0, paused=0, wrap=0.
//     Both synchronisers, debounce counters and accepted levels clear to released.
//   Key path, per key: 2-FF synchroniser, then a counter that counts
//     consecutive samples differing from the accepted level. Accepted level
//     flips when the count reaches DB_CYCLES. Any matching sample clears the count.
//     A 0->1 flip of the accepted level produces a 1-cycle press pulse. Release
//     makes no pulse. Press-to-pulse latency is 2 + DB_CYCLES + 1 clocks.
//   Modes (the led value on entry is the start value):
//     0 SHIFT_L  single bit 01->02->...->80->01.           Wrap at 80->01.
//     1 SHIFT_R  single bit 80->40->...->01->80.           Start value 8'h80.
//     2 PINGPONG single bit 01->...->80->40->...->01.      Direction reverses at
//                bit7 and at bit0, with no repeated end value. 14 steps per cycle.
//     3 FILL     01,03,07,0F,1F,3F,7F,FF,00,01.            9 steps per cycle.
//   step high while not paused: led takes its next value at that posedge.
//     Visible led latency is 1 clock.
//   wrap is high for 1 clock, registered alongside led, on the step that
//     produces the start value.
//   Mode press: mode <= mode+1, wrapping 3->0. In the same edge led loads the
//     new mode's start value. The PINGPONG direction resets to up. No wrap pulse.
//   Pause press: paused toggles. While paused, led, wrap and direction hold.
//   Simultaneous events at one edge:
//     - mode press wins over step; that step is dropped.
//     - Mode and pause presses in the same edge are both applied.
//     - A pause press plus a step in the same edge: the step is evaluated
//       against the old paused value.
//   rst wins over everything. A reset mid-press discards the partially
//     debounced state, so no stale pulse is produced after reset.
//   step pulses longer than 1 clock advance once per clock. Upstream guarantees
//     single-cycle pulses.
// TESTING
//   1 rst, then 9 step pulses in mode 0 -> led 01,02,04,..,80,01. wrap high
//     exactly on the 8th step only.
//   2 key_mode held 30 clocks (DB_CYCLES=20) -> exactly one mode increment,
//     24 clocks after the rising edge. led=8'h80 (mode 1).
//   3 key_mode toggled every 5 clocks for 200 clocks (bounce) -> mode unchanged,
//     no press pulse.
//   4 mode 2, 14 steps -> led 01,02,..,80,40,..,02,01. wrap only on the 14th step.
//     A mode press at step 10 (led=10) sets mode 3, led=01.
//   5 pause press, then 5 steps -> led and wrap frozen. A second pause press
//     plus 1 step -> led advances by one.
//   6 mode 3, 9 steps -> 03,07,0F,1F,3F,7F,FF,00,01 with wrap on the 9th.
//     rst asserted mid-sequence (led=1F) -> next cycle led=01, mode=0, paused=0.

Source files
------------

// File: rtl/run8_pattern_gen.sv
// rtl/run8_pattern_gen.sv - LED pattern generator driven by a step strobe, with debounced mode/pause keys
// Four patterns (shift left, shift right, ping-pong, fill); keys are synchronised, debounced and edge-detected.
module run8_pattern_gen #(
  parameter int DB_CYCLES = 20,
  parameter int DB_W      = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  input  logic       key_mode,
  input  logic       key_pause,
  output logic [7:0] led,
  output logic [1:0] mode,
  output logic       paused,
  output logic       wrap
);

  // bit 0 = mode key, bit 1 = pause key
  logic [1:0]      keys;
  logic [1:0]      sync1;
  logic [1:0]      sync2;
  logic [1:0]      level;
  logic [1:0]      level_d;
  logic [1:0]      press;
  logic [DB_W-1:0] cnt [2];

  assign keys = {key_pause, key_mode};

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= '0;
      sync2   <= '0;
      level   <= '0;
      level_d <= '0;
      press   <= '0;
      for (int i = 0; i < 2; i++) cnt[i] <= '0;
    end else begin
      sync1   <= keys;
      sync2   <= sync1;
      level_d <= level;
      press   <= level & ~level_d;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == level[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_W'(DB_CYCLES - 1)) begin
          level[i] <= sync2[i];
          cnt[i]   <= '0;
        end else begin
          cnt[i] <= cnt[i] + DB_W'(1);
        end
      end
    end
  end

  logic       dir_up;
  logic       dir_next;
  logic [7:0] led_next;
  logic [1:0] mode_inc;
  logic [7:0] start_cur;
  logic [7:0] start_new;

  assign mode_inc  = mode + 2'd1;
  assign start_cur = (mode == 2'd1) ? 8'h80 : 8'h01;
  assign start_new = (mode_inc == 2'd1) ? 8'h80 : 8'h01;

  // Ping-pong direction flips on arrival at either end, so no end value repeats.
  always_comb begin
    led_next = led;
    dir_next = dir_up;
    case (mode)
      2'd0: led_next = {led[6:0], led[7]};
      2'd1: led_next = {led[0], led[7:1]};
      2'd2: begin
        led_next = dir_up ? {led[6:0], 1'b0} : {1'b0, led[7:1]};
        if (led_next == 8'h80)      dir_next = 1'b0;
        else if (led_next == 8'h01) dir_next = 1'b1;
      end
      default: led_next = (led == 8'hFF) ? 8'h00 : {led[6:0], 1'b1};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      led    <= 8'h01;
      mode   <= 2'd0;
      paused <= 1'b0;
      wrap   <= 1'b0;
      dir_up <= 1'b1;
    end else begin
      if (press[0]) begin
        mode   <= mode_inc;
        led    <= start_new;
        dir_up <= 1'b1;
        wrap   <= 1'b0;
      end else if (!paused) begin
        if (step) begin
          led    <= led_next;
          dir_up <= dir_next;
          wrap   <= (led_next == start_cur);
        end else begin
          wrap <= 1'b0;
        end
      end
      if (press[1]) paused <= ~paused;
    end
  end

endmodule

// File: tb/tb_run8_pattern_gen.sv
// tb/tb_run8_pattern_gen.sv - self-checking bench for run8_pattern_gen
// Reference model tracks each pattern as a position in a per-mode sequence table.
module tb_run8_pattern_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       step;
  logic       key_mode;
  logic       key_pause;
  logic [7:0] led;
  logic [1:0] mode;
  logic       paused;
  logic       wrap;

  int tests = 0;
  int fails = 0;

  int m_mode;
  int m_pos;
  bit m_paused;
  bit m_wrap;

  run8_pattern_gen #(.DB_CYCLES(20), .DB_W(5)) dut (
    .clk(clk), .rst(rst), .step(step), .key_mode(key_mode), .key_pause(key_pause),
    .led(led), .mode(mode), .paused(paused), .wrap(wrap)
  );

  always #5 clk = ~clk;

  function automatic int seq_len(input int md);
    case (md)
      2: return 14;
      3: return 9;
      default: return 8;
    endcase
  endfunction

  function automatic logic [7:0] seq_val(input int md, input int pos);
    case (md)
      0: return 8'(1 << pos);
      1: return 8'(128 >> pos);
      2: return (pos <= 7) ? 8'(1 << pos) : 8'(1 << (14 - pos));
      default: return (pos == 8) ? 8'h00 : 8'((1 << (pos + 1)) - 1);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_led"}, led, seq_val(m_mode, m_pos));
    chk({tag, "_wrap"}, {7'b0, wrap}, {7'b0, m_wrap});
    chk({tag, "_mode"}, {6'b0, mode}, 8'(m_mode));
    chk({tag, "_paused"}, {7'b0, paused}, {7'b0, m_paused});
  endtask

  task automatic model_step();
    if (!m_paused) begin
      m_pos  = (m_pos + 1) % seq_len(m_mode);
      m_wrap = (m_pos == 0);
    end
  endtask

  task automatic model_idle();
    if (!m_paused) m_wrap = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; step = 1'b0; key_mode = 1'b0; key_pause = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_mode = 0; m_pos = 0; m_paused = 1'b0; m_wrap = 1'b0;
  endtask

  task automatic do_step(input string tag);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    model_step();
    check_all(tag);
  endtask

  // Key goes high just after an edge; the press takes effect 24 edges later.
  task automatic press_key(input bit is_mode, input bit with_step, input string tag);
    if (is_mode) key_mode = 1'b1; else key_pause = 1'b1;
    repeat (23) begin
      @(negedge clk);
      model_idle();
    end
    chk({tag, "_premode"}, {6'b0, mode}, 8'(m_mode));
    chk({tag, "_prepaused"}, {7'b0, paused}, {7'b0, m_paused});
    step = with_step;
    @(negedge clk);
    step = 1'b0;
    if (is_mode) begin
      m_mode = (m_mode + 1) % 4;
      m_pos  = 0;
      m_wrap = 1'b0;
    end else begin
      if (with_step) model_step(); else model_idle();
      m_paused = !m_paused;
    end
    check_all(tag);
    repeat (6) begin
      @(negedge clk);
      model_idle();
    end
    key_mode = 1'b0; key_pause = 1'b0;
    repeat (30) begin
      @(negedge clk);
      model_idle();
    end
    check_all({tag, "_rel"});
  endtask

  initial begin
    rst = 1'b1; step = 1'b0; key_mode = 1'b0; key_pause = 1'b0;
    do_reset();
    chk("rst_led", led, 8'h01);
    chk("rst_mode", {6'b0, mode}, 8'h00);
    chk("rst_paused", {7'b0, paused}, 8'h00);
    chk("rst_wrap", {7'b0, wrap}, 8'h00);

    for (int i = 0; i < 9; i++) do_step("shl");
    @(negedge clk); model_idle();
    check_all("shl_idle");

    press_key(1'b1, 1'b0, "mode1");
    chk("mode1_start", led, 8'h80);
    for (int i = 0; i < 9; i++) do_step("shr");

    for (int i = 0; i < 40; i++) begin
      key_mode = ~key_mode;
      repeat (5) begin
        @(negedge clk);
        model_idle();
      end
    end
    key_mode = 1'b0;
    repeat (30) begin
      @(negedge clk);
      model_idle();
    end
    check_all("bounce");

    press_key(1'b1, 1'b0, "mode2");
    for (int i = 0; i < 14; i++) do_step("pp");
    for (int i = 0; i < 4; i++) do_step("pp2");
    chk("pp_at10", led, 8'h10);
    press_key(1'b1, 1'b1, "mode3");
    chk("mode3_start", led, 8'h01);

    press_key(1'b0, 1'b0, "pause_on");
    for (int i = 0; i < 5; i++) do_step("frozen");
    press_key(1'b0, 1'b0, "pause_off");
    do_step("resume");
    chk("resume_led", led, 8'h03);

    for (int i = 0; i < 9; i++) do_step("fill");
    for (int i = 0; i < 12 && m_pos != 4; i++) do_step("fill2");
    chk("fill_1f", led, 8'h1F);
    do_reset();
    chk("rst2_led", led, 8'h01);
    chk("rst2_mode", {6'b0, mode}, 8'h00);
    chk("rst2_paused", {7'b0, paused}, 8'h00);

    key_mode = 1'b1;
    repeat (12) @(negedge clk);
    rst = 1'b1;
    key_mode = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    check_all("rst_midpress");

    for (int i = 0; i < 150; i++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r == 0)      press_key(1'b1, 1'($urandom_range(0, 1)), "rnd_mode");
      else if (r == 1) press_key(1'b0, 1'($urandom_range(0, 1)), "rnd_pause");
      else if (r < 5) begin
        @(negedge clk);
        model_idle();
        check_all("rnd_idle");
      end else begin
        do_step("rnd_step");
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
